// File: rtl/gpio_apb_filtered.sv
// rtl/gpio_apb_filtered.sv - APB GPIO with per-pin debounce filter and latched interrupts
module gpio_apb_filtered #(
  parameter int NrGPIOs       = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SyncStages    = 2,
  parameter int DebounceWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic [NrGPIOs-1:0]      gpio_in,
  output logic [NrGPIOs-1:0]      gpio_out,
  output logic [NrGPIOs-1:0]      gpio_tx_en_o,
  output logic [NrGPIOs-1:0]      gpio_in_sync_o,
  output logic                    global_interrupt_o,
  output logic [NrGPIOs-1:0]      pin_level_interrupts_o
);

  localparam int N  = NrGPIOs;
  localparam int DW = DebounceWidth;

  logic [3:0]            idx;
  logic                  access, we;
  logic [DATA_WIDTH-1:0] bmask;
  logic [N-1:0]          wmask, wdata, w1c;
  logic                  addr_unused;

  logic [N-1:0]  sync_q [SyncStages];
  logic [DW-1:0] cnt_q  [N];
  logic [DW-1:0] cnt_d  [N];
  logic [N-1:0]  filt_q, filt_d, prev_q, s, set_ev;
  logic [N-1:0]  dir_q, dir_d, out_q, out_d;
  logic [N-1:0]  en_rise_q, en_rise_d, en_fall_q, en_fall_d;
  logic [N-1:0]  en_high_q, en_high_d, en_low_q, en_low_d;
  logic [N-1:0]  status_q, status_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          gen_q, gen_d;

  assign idx         = paddr_i[5:2];
  assign addr_unused = ^{paddr_i[ADDR_WIDTH-1:6], paddr_i[1:0]};
  assign access      = psel_i & penable_i;
  assign pslverr_o   = access & ((idx > 4'd12) | (pwrite_i & ((idx == 4'd0) | (idx == 4'd5))));
  assign we          = access & pwrite_i & ~pslverr_o;
  assign pready_o    = 1'b1;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) bmask[b*8 +: 8] = {8{pstrb_i[b]}};
  end

  assign wmask = bmask[N-1:0];
  assign wdata = pwdata_i[N-1:0] & wmask;
  assign s     = sync_q[SyncStages-1];

  function automatic logic [N-1:0] merge(input logic [N-1:0] old_v, input logic [N-1:0] m,
                                         input logic [N-1:0] d);
    return (old_v & ~m) | d;
  endfunction

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    deb_d     = deb_q;
    en_rise_d = en_rise_q;
    en_fall_d = en_fall_q;
    en_high_d = en_high_q;
    en_low_d  = en_low_q;
    gen_d     = gen_q;
    w1c       = '0;
    if (we) begin
      case (idx)
        4'd1:  dir_d     = merge(dir_q, wmask, wdata);
        4'd2:  out_d     = merge(out_q, wmask, wdata);
        4'd3:  out_d     = out_q | wdata;
        4'd4:  out_d     = out_q & ~wdata;
        4'd6:  deb_d     = (deb_q & ~bmask[DW-1:0]) | (pwdata_i[DW-1:0] & bmask[DW-1:0]);
        4'd7:  en_rise_d = merge(en_rise_q, wmask, wdata);
        4'd8:  en_fall_d = merge(en_fall_q, wmask, wdata);
        4'd9:  en_high_d = merge(en_high_q, wmask, wdata);
        4'd10: en_low_d  = merge(en_low_q, wmask, wdata);
        4'd11: w1c       = wdata;
        4'd12: gen_d     = pstrb_i[0] ? pwdata_i[0] : gen_q;
        default: ;
      endcase
    end
  end

  // Counter never exceeds the threshold, so c + 1 cannot wrap.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= deb_q) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign set_ev   = (filt_q & ~prev_q & en_rise_q) | (~filt_q & prev_q & en_fall_q) |
                    (filt_q & en_high_q) | (~filt_q & en_low_q);
  assign status_d = (status_q & ~w1c) | set_ev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      dir_q     <= '0;
      out_q     <= '0;
      deb_q     <= '0;
      en_rise_q <= '0;
      en_fall_q <= '0;
      en_high_q <= '0;
      en_low_q  <= '0;
      status_q  <= '0;
      gen_q     <= 1'b0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      prev_q    <= filt_q;
      dir_q     <= dir_d;
      out_q     <= out_d;
      deb_q     <= deb_d;
      en_rise_q <= en_rise_d;
      en_fall_q <= en_fall_d;
      en_high_q <= en_high_d;
      en_low_q  <= en_low_d;
      status_q  <= status_d;
      gen_q     <= gen_d;
    end
  end

  always_comb begin
    prdata_o = '0;
    if (psel_i) begin
      case (idx)
        4'd0: begin
          prdata_o[7:0]  = 8'(NrGPIOs);
          prdata_o[15:8] = 8'(DebounceWidth);
        end
        4'd1:  prdata_o[N-1:0]  = dir_q;
        4'd2:  prdata_o[N-1:0]  = out_q;
        4'd5:  prdata_o[N-1:0]  = filt_q;
        4'd6:  prdata_o[DW-1:0] = deb_q;
        4'd7:  prdata_o[N-1:0]  = en_rise_q;
        4'd8:  prdata_o[N-1:0]  = en_fall_q;
        4'd9:  prdata_o[N-1:0]  = en_high_q;
        4'd10: prdata_o[N-1:0]  = en_low_q;
        4'd11: prdata_o[N-1:0]  = status_q;
        4'd12: prdata_o[0]      = gen_q;
        default: ;
      endcase
    end
  end

  assign gpio_out               = out_q;
  assign gpio_tx_en_o           = dir_q;
  assign gpio_in_sync_o         = s;
  assign pin_level_interrupts_o = status_q;
  assign global_interrupt_o     = (|status_q) & gen_q;

endmodule

// File: tb/tb_gpio_apb_filtered.sv
// tb/tb_gpio_apb_filtered.sv - self-checking bench for gpio_apb_filtered
module tb_gpio_apb_filtered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [31:0] gpio_in, gpio_out, tx_en, in_sync, pin_irq;
  logic        girq;

  gpio_apb_filtered dut (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_tx_en_o(tx_en), .gpio_in_sync_o(in_sync), .global_interrupt_o(girq),
    .pin_level_interrupts_o(pin_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic        err;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb);
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata;
    er = pslverr;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got access at %h expected a queued entry", addr);
    end else begin
      e = sb_q.pop_front();
      if (e.chk_rd) check({e.name, "_rd"}, rd, e.rd);
      check({e.name, "_err"}, 32'(er), 32'(e.err));
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_reg(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic err);
    exp_t e;
    e.name = name; e.chk_rd = 1'b0; e.rd = '0; e.err = err;
    sb_q.push_back(e);
    apb(1'b1, a, d, s);
  endtask

  task automatic rd_reg(input string name, input logic [31:0] a, input logic [31:0] exp,
                        input logic err);
    exp_t e;
    e.name = name; e.chk_rd = 1'b1; e.rd = exp; e.err = err;
    sb_q.push_back(e);
    apb(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] e, input logic er);
    vec_t v;
    v = '{wr, a, d, s, e, er};
    vt.push_back(v);
  endtask

  // Cycles (negedges) until bit b of sel first goes high; 0 if never within limit.
  task automatic watch(input int sel, input int b, input int limit, output int cyc);
    logic [31:0] v;
    cyc = 0;
    for (int i = 1; i <= limit && cyc == 0; i++) begin
      @(negedge clk);
      #1;
      v = (sel == 0) ? prdata : (sel == 1) ? in_sync : (sel == 2) ? pin_irq : 32'(girq);
      if (v[b]) cyc = i;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; gpio_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_tx_en", tx_en, 32'h0);
    check("rst_pin_irq", pin_irq, 32'h0);
    check("rst_girq", 32'(girq), 32'h0);
    check("pready", 32'(pready), 32'h1);

    add(0, 32'h00, 0, 4'h0, 32'h0820, 0);
    for (int a = 4; a <= 32'h30; a += 4) add(0, 32'(a), 0, 4'h0, 32'h0, 0);
    add(0, 32'h34, 0, 4'h0, 32'h0, 1);
    add(0, 32'h40, 0, 4'h0, 32'h0820, 0);
    add(1, 32'h00, 32'hFFFF, 4'hF, 0, 1);
    add(0, 32'h00, 0, 4'h0, 32'h0820, 0);
    add(1, 32'h14, 32'hFF, 4'hF, 0, 1);
    add(0, 32'h14, 0, 4'h0, 32'h0, 0);
    add(1, 32'h38, 32'hFF, 4'hF, 0, 1);
    add(1, 32'h08, 32'hF0, 4'hF, 0, 0);
    add(1, 32'h0C, 32'h0F, 4'hF, 0, 0);
    add(1, 32'h10, 32'h30, 4'hF, 0, 0);
    add(0, 32'h08, 0, 4'h0, 32'hCF, 0);
    add(0, 32'h0C, 0, 4'h0, 32'h0, 0);
    add(0, 32'h10, 0, 4'h0, 32'h0, 0);
    add(1, 32'h04, 32'hA5A5_A5A5, 4'b0101, 0, 0);
    add(0, 32'h104, 0, 4'h0, 32'h00A5_00A5, 0);
    add(1, 32'h18, 32'h1FF, 4'b0011, 0, 0);
    add(0, 32'h18, 0, 4'h0, 32'hFF, 0);
    add(1, 32'h30, 32'hFFFF_FFFF, 4'b1110, 0, 0);
    add(0, 32'h30, 0, 4'h0, 32'h0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) wr_reg($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].strb, vt[i].err);
      else          rd_reg($sformatf("vec%0d", i), vt[i].addr, vt[i].exp, vt[i].err);
    end
    check("out_cf", gpio_out, 32'hCF);
    check("dir_pins", tx_en, 32'h00A5_00A5);

    wr_reg("out_strb", 32'h08, 32'hFFFF_FF00, 4'b0001, 0);
    check("out_strb_pins", gpio_out, 32'h0);

    // Debounce: N = 3, a 3-cycle pulse is rejected, a held change lands after 6 cycles.
    wr_reg("deb3", 32'h18, 32'h3, 4'h1, 0);
    gpio_in[5] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[5] = 1'b0;
    repeat (10) @(negedge clk);
    rd_reg("pulse_in", 32'h14, 32'h0, 0);

    psel = 1'b1; paddr = 32'h14; gpio_in[5] = 1'b1;
    fork
      begin int c2; watch(1, 5, 10, c2); check("sync_latency", 32'(c2), 32'd2); end
      begin watch(0, 5, 12, cyc); end
    join
    psel = 1'b0;
    check("in_latency", 32'(cyc), 32'd6);

    // Rising edge interrupt on pin 2.
    wr_reg("en_rise", 32'h1C, 32'h4, 4'hF, 0);
    wr_reg("gen_on", 32'h30, 32'h1, 4'h1, 0);
    gpio_in[2] = 1'b1;
    watch(3, 0, 15, cyc);
    check("rise_latency", 32'(cyc), 32'd7);
    check("rise_status", pin_irq, 32'h4);
    wr_reg("gen_off", 32'h30, 32'h0, 4'h1, 0);
    check("gen_off_girq", 32'(girq), 32'h0);
    rd_reg("status_kept", 32'h2C, 32'h4, 0);
    wr_reg("gen_on2", 32'h30, 32'h1, 4'h1, 0);
    check("gen_on_girq", 32'(girq), 32'h1);
    wr_reg("w1c_rise", 32'h2C, 32'h4, 4'hF, 0);
    check("w1c_status", pin_irq, 32'h0);
    check("w1c_girq", 32'(girq), 32'h0);
    gpio_in[2] = 1'b0;
    repeat (12) @(negedge clk);
    check("fall_no_set", pin_irq, 32'h0);

    // High level on pin 7: clear collides with set, set wins.
    wr_reg("en_high", 32'h24, 32'h80, 4'hF, 0);
    gpio_in[7] = 1'b1;
    watch(2, 7, 15, cyc);
    check("high_latency", 32'(cyc), 32'd7);
    wr_reg("w1c_high", 32'h2C, 32'h80, 4'hF, 0);
    check("high_set_wins", pin_irq & 32'h80, 32'h80);
    gpio_in[7] = 1'b0;
    repeat (12) @(negedge clk);
    check("high_latched", pin_irq & 32'h80, 32'h80);
    wr_reg("w1c_high2", 32'h2C, 32'h80, 4'hF, 0);
    check("high_cleared", pin_irq, 32'h0);
    repeat (5) @(negedge clk);
    check("high_stays_clear", pin_irq, 32'h0);

    // Reset while pin 9 has c = 2.
    wr_reg("out_pre_rst", 32'h08, 32'h1234, 4'hF, 0);
    check("out_pre_rst_pins", gpio_out, 32'h1234);
    gpio_in[9] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", gpio_out, 32'h0);
    check("mid_rst_dir", tx_en, 32'h0);
    check("mid_rst_sync", in_sync, 32'h0);
    check("mid_rst_irq", pin_irq, 32'h0);
    check("mid_rst_girq", 32'(girq), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; psel = 1'b1; paddr = 32'h14;
    watch(0, 9, 10, cyc);
    psel = 1'b0;
    check("post_rst_latency", 32'(cyc), 32'd3);
    @(negedge clk);
    rd_reg("post_rst_deb", 32'h18, 32'h0, 0);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
